// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/load/shift/rotate/asr/clear in single steps, plus a
// multi-cycle "shift by N" sequencer that reports progress on busy and a one-cycle done.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROTL  = 3'b100;
    localparam logic [2:0] M_ROTR  = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Handshake: start is sampled only in IDLE with a shifting mode; busy is high while
    // steps remain after the current one, and done pulses for one cycle on completion.
    state_t           state, state_next;
    logic [2:0]       run_mode, run_mode_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] q_next;
    logic             sout_next, busy_next, done_next;

    logic [2:0]       step_mode;
    logic             do_step;
    logic [WIDTH-1:0] step_q;
    logic             step_sout;
    logic             step_sout_en;
    logic             mode_is_shift;

    assign mode_is_shift = (mode >= M_SHL) && (mode <= M_ASR);

    // One-step datapath shared by single-cycle operations and the sequencer.
    always_comb begin
        step_q       = q;
        step_sout    = sout;
        step_sout_en = 1'b0;
        case (step_mode)
            M_HOLD:  step_q = q;
            M_LOAD:  step_q = d;
            M_SHL: begin
                step_q       = {q[WIDTH-2:0], sin};
                step_sout    = q[WIDTH-1];
                step_sout_en = 1'b1;
            end
            M_SHR: begin
                step_q       = {sin, q[WIDTH-1:1]};
                step_sout    = q[0];
                step_sout_en = 1'b1;
            end
            M_ROTL: begin
                step_q       = {q[WIDTH-2:0], q[WIDTH-1]};
                step_sout    = q[WIDTH-1];
                step_sout_en = 1'b1;
            end
            M_ROTR: begin
                step_q       = {q[0], q[WIDTH-1:1]};
                step_sout    = q[0];
                step_sout_en = 1'b1;
            end
            M_ASR: begin
                step_q       = {q[WIDTH-1], q[WIDTH-1:1]};
                step_sout    = q[0];
                step_sout_en = 1'b1;
            end
            M_CLEAR: step_q = '0;
            default: step_q = q;
        endcase
    end

    always_comb begin
        state_next    = state;
        run_mode_next = run_mode;
        cnt_next      = cnt;
        busy_next     = busy;
        done_next     = 1'b0;
        step_mode     = mode;
        do_step       = 1'b0;
        case (state)
            IDLE: begin
                if (start && mode_is_shift) begin
                    run_mode_next = mode;
                    if (amount == '0) begin
                        done_next = 1'b1;
                    end else if (amount == CNT_W'(1)) begin
                        do_step   = 1'b1;
                        done_next = 1'b1;
                    end else begin
                        do_step    = 1'b1;
                        cnt_next   = amount - CNT_W'(1);
                        busy_next  = 1'b1;
                        state_next = RUN;
                    end
                end else if (en) begin
                    do_step = 1'b1;
                end
            end
            RUN: begin
                step_mode = run_mode;
                // busy drops with the last step; the following edge closes the run.
                if (cnt == '0) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    do_step   = 1'b1;
                    cnt_next  = cnt - CNT_W'(1);
                    busy_next = (cnt != CNT_W'(1));
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
        q_next    = do_step ? step_q : q;
        sout_next = (do_step && step_sout_en) ? step_sout : sout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            run_mode <= M_HOLD;
            cnt      <= '0;
            q        <= '0;
            sout     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            run_mode <= run_mode_next;
            cnt      <= cnt_next;
            q        <= q_next;
            sout     <= sout_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: the driver pushes the hand-computed post-edge
// outputs into a queue and a negedge monitor pops and compares them.
module tb_univ_shift_reg;

    logic       clk;
    logic       rst;
    logic       en;
    logic       start;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin;
    logic [3:0] amount;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;

    logic [10:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .d(d),
        .sin(sin), .amount(amount), .q(q), .sout(sout), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input logic r, input logic e, input logic s, input logic [2:0] m,
                       input logic [7:0] dd, input logic si, input logic [3:0] a,
                       input logic [7:0] eq, input logic es, input logic eb,
                       input logic edn, input string nm);
        rst = r; en = e; start = s; mode = m; d = dd; sin = si; amount = a;
        @(posedge clk);
        exp_q.push_back({eq, es, eb, edn});
        name_q.push_back(nm);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [10:0] exp_v;
            string       nm;
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            n_checks++;
            if ({q, sout, busy, done} !== exp_v) begin
                n_fail++;
                $display("FAIL %s: got q=%h sout=%b busy=%b done=%b, expected q=%h sout=%b busy=%b done=%b",
                         nm, q, sout, busy, done, exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ek;
        rst = 1'b1; en = 1'b0; start = 1'b0; mode = 3'b000; d = 8'h00; sin = 1'b0; amount = 4'd0;

        // reset overrides a load
        cyc(1, 1, 0, 3'b001, 8'hFF, 0, 0, 8'h00, 0, 0, 0, "reset_1");
        cyc(1, 1, 0, 3'b001, 8'hFF, 0, 0, 8'h00, 0, 0, 0, "reset_2");
        cyc(0, 1, 0, 3'b001, 8'hA5, 0, 0, 8'hA5, 0, 0, 0, "load_a5");

        // single-step operations
        cyc(0, 1, 0, 3'b100, 8'h00, 0, 0, 8'h4B, 1, 0, 0, "rotl");
        cyc(0, 1, 0, 3'b101, 8'h00, 0, 0, 8'hA5, 1, 0, 0, "rotr");
        cyc(0, 1, 0, 3'b011, 8'h00, 0, 0, 8'h52, 1, 0, 0, "shr_sin0");
        cyc(0, 1, 0, 3'b001, 8'h80, 0, 0, 8'h80, 1, 0, 0, "load_80");
        cyc(0, 1, 0, 3'b110, 8'h00, 0, 0, 8'hC0, 0, 0, 0, "asr_80");
        cyc(0, 1, 0, 3'b111, 8'h00, 0, 0, 8'h00, 0, 0, 0, "clear");
        cyc(0, 1, 0, 3'b001, 8'hA5, 0, 0, 8'hA5, 0, 0, 0, "load_a5_b");

        // hold with en low, then explicit hold mode
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 0, 3'b010, 8'h00, 1, 0, 8'hA5, 0, 0, 0, "hold_en0");
        cyc(0, 1, 0, 3'b000, 8'h00, 1, 0, 8'hA5, 0, 0, 0, "hold_mode0");
        cyc(0, 1, 0, 3'b010, 8'h00, 1, 0, 8'h4B, 1, 0, 0, "shl_sin1");

        // multi-cycle rotl by 3 from 01
        cyc(0, 1, 0, 3'b001, 8'h01, 0, 0, 8'h01, 1, 0, 0, "load_01");
        cyc(0, 0, 1, 3'b100, 8'h00, 0, 3, 8'h02, 0, 1, 0, "rotl3_step1");
        cyc(0, 1, 0, 3'b000, 8'h00, 0, 0, 8'h04, 0, 1, 0, "rotl3_step2");
        cyc(0, 0, 0, 3'b000, 8'h00, 0, 0, 8'h08, 0, 0, 0, "rotl3_step3");
        cyc(0, 0, 0, 3'b000, 8'h00, 0, 0, 8'h08, 0, 0, 1, "rotl3_done");
        cyc(0, 0, 0, 3'b000, 8'h00, 0, 0, 8'h08, 0, 0, 0, "rotl3_done_low");

        // amount = 0: no step, done pulse only
        cyc(0, 0, 1, 3'b010, 8'h00, 1, 0, 8'h08, 0, 0, 1, "amt0_done");
        cyc(0, 0, 0, 3'b000, 8'h00, 1, 0, 8'h08, 0, 0, 0, "amt0_after");

        // shl by 9 with sin=1 from 00; start with clear mid-run is dropped
        cyc(0, 1, 0, 3'b111, 8'h00, 0, 0, 8'h00, 0, 0, 0, "clear_b");
        cyc(0, 0, 1, 3'b010, 8'h00, 1, 9, 8'h01, 0, 1, 0, "shl9_step1");
        for (int k = 2; k <= 9; k++) begin
            ek = (k >= 8) ? 8'hFF : 8'((1 << k) - 1);
            if (k == 3)
                cyc(0, 1, 1, 3'b111, 8'h5A, 1, 2, ek, 1'(k == 9), 1'(k != 9), 0, "shl9_restart_ignored");
            else
                cyc(0, 0, 0, 3'b000, 8'h00, 1, 0, ek, 1'(k == 9), 1'(k != 9), 0, "shl9_step");
        end
        cyc(0, 0, 0, 3'b000, 8'h00, 1, 0, 8'hFF, 1, 0, 1, "shl9_done");

        // amount = 1, and a new start accepted while done is high
        cyc(0, 1, 0, 3'b001, 8'h81, 0, 0, 8'h81, 1, 0, 0, "load_81");
        cyc(0, 0, 1, 3'b101, 8'h00, 0, 1, 8'hC0, 1, 0, 1, "rotr1_done");
        cyc(0, 0, 1, 3'b100, 8'h00, 0, 1, 8'h81, 1, 0, 1, "rotl1_back_to_back");
        cyc(0, 0, 0, 3'b000, 8'h00, 0, 0, 8'h81, 1, 0, 0, "rotl1_done_low");

        // reset during a shr-by-5 run
        cyc(0, 1, 0, 3'b001, 8'hF0, 0, 0, 8'hF0, 1, 0, 0, "load_f0");
        cyc(0, 0, 1, 3'b011, 8'h00, 0, 5, 8'h78, 0, 1, 0, "shr5_step1");
        cyc(0, 0, 0, 3'b000, 8'h00, 0, 0, 8'h3C, 0, 1, 0, "shr5_step2");
        cyc(1, 0, 0, 3'b000, 8'h00, 0, 0, 8'h00, 0, 0, 0, "midrun_reset");
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 0, 3'b000, 8'h00, 0, 0, 8'h00, 0, 0, 0, "no_done_after_reset");

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
